memory_stage: RTL and testbench
===============================

# memory_stage

Memory stage of the five-stage pipeline: consumes the execute/memory latch outputs, runs the data-cache transaction (load, store, LL, SC), and owns the memory/writeback latch that feeds the register-file write port. It holds a single-entry link register for LL/SC and raises a stall toward the hazard unit while a cache access is outstanding.

## Interface
Parameters
- none; widths come from the shared package (word_t = 32 bits, regbits_t = 5 bits)

Ports
- CLK  in  1  pipeline clock, rising edge
- RST  in  1  asynchronous, active-high reset
- ihit  in  1  pipeline advance enable from the fetch side
- flush  in  1  turn the incoming MEM op into a bubble
- dREN_in, dWEN_in, datomic_in  in  1 each  read, write, and atomic qualifier (LL = dREN+datomic, SC = dWEN+datomic)
- MemtoReg_in, RegWrite_in, jal_in, halt_in  in  1 each  control from the execute/memory latch
- aluout_in  in  32  effective address or ALU result (LUI already resolved)
- rdat2_in  in  32  store data
- wsel_in  in  5  destination register
- pc4_in, instruction_in  in  32 each  carried for JAL and trace
- dhit  in  1  data-cache completion, one cycle wide
- dmemload  in  32  load data, valid with dhit
- link_inv  in  1  coherence invalidate strobe
- link_inv_addr  in  32  invalidated address
- dmemREN, dmemWEN  out  1 each  cache request, registered
- dmemaddr, dmemstore  out  32 each  registered address and store data
- mem_stall  out  1  MEM stage cannot advance
- wb_wdat  out  32  writeback data
- wb_wsel  out  5  writeback register
- wb_RegWrite, wb_halt  out  1 each
- wb_pc4, wb_instruction  out  32 each

## Operation
- FSM states are IDLE, ACCESS, and DONE.
  - IDLE → ACCESS when dREN_in or dWEN_in is high, except for an SC that fails the link check. A failing SC goes directly to DONE with no cache access.
  - ACCESS holds dmemREN/dmemWEN, dmemaddr, and dmemstore stable until dhit. On dhit it captures dmemload into the load buffer and moves to DONE.
  - DONE → IDLE when ihit is high. The writeback latch loads on that same edge.
  - A non-memory op stays in IDLE. The latch loads on ihit & !mem_stall.
- mem_stall = (state==IDLE & memory op & not failing-SC) | (state==ACCESS).
- Writeback data priority:
  - jal_in → pc4_in
  - SC → {31'b0, success}
  - MemtoReg_in → load buffer
  - otherwise → aluout_in
- Word addressing is aligned; dmemaddr[1:0] passes through unchanged.
- Link register holds a valid bit and a 32-bit address.
  - LL sets it on dhit to aluout_in.
  - A successful SC clears it.
  - Any completed SW or SC whose address equals the link address clears it.
  - link_inv with a matching link_inv_addr clears it.
- SC success requires a valid link with a matching address, evaluated in IDLE.
  - If link_inv to that address arrives in the same cycle, the SC fails.
  - If link_inv hits during ACCESS of an SC, the write still completes and SC returns 1, because the coherence order was decided at issue.
- flush during IDLE or DONE: the latch loads a bubble (RegWrite=0, halt=0, instruction=0).
- flush during ACCESS: the transaction completes, and its result loads as a bubble. An LL in this case does not set the link.
- wb_halt is sticky once set, until RST.

## Timing
- Cache request latency is one cycle: the op is presented in cycle N and dmemREN/dmemWEN are high from N+1.
- The earliest writeback is the edge after dhit; a load occupies MEM for at least 3 cycles.
- Non-memory ops and failing SC take 1 cycle.
- dhit outside ACCESS is ignored.
- On RST, every output is 0, the state is IDLE, and the link is invalid.
- RST during ACCESS drops the request immediately. The cache side tolerates an abandoned request.

## Configuration
- LLSC_EN defined: LL/SC behaviour as above, including the link register and link_inv ports.
- LLSC_EN undefined:
  - datomic_in is ignored; LL behaves as LW and SC behaves as SW.
  - SC writes back aluout_in, not a status value.
  - The link register is removed and link_inv/link_inv_addr are left unconnected.

## Structure
- cpu_types_pkg holds word_t, regbits_t, and the memstage_state_t enum (IDLE, ACCESS, DONE).
- Sub-module llsc_link holds the link register, the match/clear logic, and the SC success output. It is instantiated only under LLSC_EN.

## Test plan
- LW to 0x0040, dhit 2 cycles after request, ihit high → dmemREN high for 2 cycles, mem_stall high, then wb_wdat = dmemload and wb_wsel = wsel_in.
- SW of 0xDEADBEEF to 0x0080 → dmemWEN, dmemaddr = 0x0080, dmemstore = 0xDEADBEEF; wb_RegWrite = 0.
- LL at 0x0100, then SC at 0x0100 → SC issues dmemWEN and wb_wdat = 1; a second SC to 0x0100 gives no dmemWEN, wb_wdat = 0, and 1-cycle latency.
- LL at 0x0100, link_inv with addr 0x0100, then SC → SC fails (0), no write. Repeat with link_inv in the same cycle as SC → same result.
- dhit arrives while ihit is low → state holds in DONE with mem_stall low; the latch loads on the first ihit.
- RST asserted mid-ACCESS → dmemREN drops at once, all wb_* are 0, and a following SC fails.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared word/register types and the memory-stage FSM encoding.
// Latency: n/a (types only).
// Backpressure: n/a.
package cpu_types_pkg;
    localparam int WORD_W = 32;
    localparam int REG_W  = 5;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [REG_W-1:0]  regbits_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } memstage_state_t;

    // SC writes its outcome to the destination register as 0 or 1.
    function automatic word_t sc_status(input logic ok);
        return {{(WORD_W-1){1'b0}}, ok};
    endfunction
endpackage

// File: rtl/memory_stage_llsc_link.sv
// llsc_link: single-entry LL/SC reservation (valid bit + word address).
// Latency: set/clear take effect on the next edge; sc_ok_o is combinational.
// Backpressure: none; driven purely by memory_stage events.
module llsc_link
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  RST,
    input  logic  set_i,
    input  word_t set_addr_i,
    input  logic  wr_done_i,
    input  word_t wr_addr_i,
    input  logic  inv_i,
    input  word_t inv_addr_i,
    input  word_t sc_addr_i,
    output logic  sc_ok_o
);
    logic  valid_q, valid_d;
    word_t addr_q, addr_d;

    // Next reservation: writes and snoops to the linked word drop it; a completing LL replaces it.
    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        if (wr_done_i && (wr_addr_i == addr_q)) valid_d = 1'b0;
        if (inv_i && (inv_addr_i == addr_q))    valid_d = 1'b0;
        if (set_i) begin
            addr_d  = set_addr_i;
            // A snoop to the same word on the completing edge wins: the SC must not trust it.
            valid_d = !(inv_i && (inv_addr_i == set_addr_i));
        end
    end

    // Reservation register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
        end
    end

    assign sc_ok_o = valid_q && (addr_q == sc_addr_i) && !(inv_i && (inv_addr_i == sc_addr_i));
endmodule

// File: rtl/memory_stage.sv
// memory_stage: data-cache access (LW/SW, LL/SC when LLSC_EN is defined) plus the MEM/WB latch.
// Latency: request registered one cycle after issue; writeback on the ihit edge after dhit.
// Backpressure: mem_stall holds the upstream latch while an access is pending; DONE waits for ihit.
module memory_stage
    import cpu_types_pkg::*;
(
    input  logic     CLK,
    input  logic     RST,
    input  logic     ihit,
    input  logic     flush,
    input  logic     dREN_in,
    input  logic     dWEN_in,
    input  logic     datomic_in,
    input  logic     MemtoReg_in,
    input  logic     RegWrite_in,
    input  logic     jal_in,
    input  logic     halt_in,
    input  word_t    aluout_in,
    input  word_t    rdat2_in,
    input  regbits_t wsel_in,
    input  word_t    pc4_in,
    input  word_t    instruction_in,
    input  logic     dhit,
    input  word_t    dmemload,
    input  logic     link_inv,
    input  word_t    link_inv_addr,
    output logic     dmemREN,
    output logic     dmemWEN,
    output word_t    dmemaddr,
    output word_t    dmemstore,
    output logic     mem_stall,
    output word_t    wb_wdat,
    output regbits_t wb_wsel,
    output logic     wb_RegWrite,
    output logic     wb_halt,
    output word_t    wb_pc4,
    output word_t    wb_instruction
);
    memstage_state_t state_q, state_d;
    logic     dmemREN_q, dmemWEN_q, flushed_q, wb_RegWrite_q, wb_halt_q;
    word_t    dmemaddr_q, dmemstore_q, loadbuf_q, wb_wdat_q, wb_pc4_q, wb_instruction_q;
    regbits_t wb_wsel_q;
    word_t    wdat_d;
    logic     is_mem_op, sc_fail, acc_done, load_wb, bubble, start_acc;

    // A flushed op never starts a cache access; it just drains as a bubble.
    assign is_mem_op = (dREN_in | dWEN_in) & ~flush;
    assign acc_done  = (state_q == ACCESS) & dhit;
    assign bubble    = flush | ((state_q == DONE) & flushed_q);
    assign start_acc = (state_q == IDLE) & (state_d == ACCESS);

`ifdef LLSC_EN
    logic is_ll, is_sc, sc_ok, sc_ok_q, sc_res;
    assign is_ll   = dREN_in & datomic_in;
    assign is_sc   = dWEN_in & datomic_in;
    assign sc_fail = is_sc & ~sc_ok;
    // Success is fixed at issue; in DONE use the captured verdict, later snoops do not matter.
    assign sc_res  = (state_q == DONE) ? sc_ok_q : sc_ok;

    llsc_link u_link (
        .CLK        (CLK),
        .RST        (RST),
        .set_i      (acc_done & is_ll & ~flushed_q & ~flush),
        .set_addr_i (dmemaddr_q),
        .wr_done_i  (acc_done & dmemWEN_q),
        .wr_addr_i  (dmemaddr_q),
        .inv_i      (link_inv),
        .inv_addr_i (link_inv_addr),
        .sc_addr_i  (aluout_in),
        .sc_ok_o    (sc_ok)
    );

    // Capture the SC verdict while the op sits in IDLE.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)                    sc_ok_q <= 1'b0;
        else if (state_q == IDLE)   sc_ok_q <= sc_ok;
    end
`else
    logic unused_llsc;
    assign sc_fail     = 1'b0;
    assign unused_llsc = ^{datomic_in, link_inv, link_inv_addr};
`endif

    // Next state and writeback-latch enable.
    always_comb begin
        state_d = state_q;
        load_wb = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_mem_op & ~sc_fail)             state_d = ACCESS;
                else if (is_mem_op & sc_fail & ~ihit) state_d = DONE;
                else                                  load_wb = ihit;
            end
            ACCESS: if (dhit) state_d = DONE;
            DONE: begin
                if (ihit) begin
                    state_d = IDLE;
                    load_wb = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Cache request registers: loaded on entry to ACCESS, held until dhit.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dmemREN_q   <= 1'b0;
            dmemWEN_q   <= 1'b0;
            dmemaddr_q  <= '0;
            dmemstore_q <= '0;
        end else if (start_acc) begin
            dmemREN_q   <= dREN_in;
            dmemWEN_q   <= dWEN_in;
            dmemaddr_q  <= aluout_in;
            dmemstore_q <= rdat2_in;
        end else if (acc_done) begin
            dmemREN_q   <= 1'b0;
            dmemWEN_q   <= 1'b0;
        end
    end

    // Load buffer and the "flushed while in flight" marker.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            loadbuf_q <= '0;
            flushed_q <= 1'b0;
        end else begin
            if (acc_done & dmemREN_q)               loadbuf_q <= dmemload;
            if (state_q == IDLE)                    flushed_q <= 1'b0;
            else if ((state_q == ACCESS) & flush)   flushed_q <= 1'b1;
        end
    end

    // Writeback data select: JAL link, SC status, load data, else ALU result.
    always_comb begin
        wdat_d = aluout_in;
        if (jal_in)           wdat_d = pc4_in;
`ifdef LLSC_EN
        else if (is_sc)       wdat_d = sc_status(sc_res);
`endif
        else if (MemtoReg_in) wdat_d = loadbuf_q;
    end

    // MEM/WB latch; halt is sticky until reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wb_wdat_q        <= '0;
            wb_wsel_q        <= '0;
            wb_RegWrite_q    <= 1'b0;
            wb_halt_q        <= 1'b0;
            wb_pc4_q         <= '0;
            wb_instruction_q <= '0;
        end else if (load_wb) begin
            wb_wdat_q        <= wdat_d;
            wb_wsel_q        <= wsel_in;
            wb_RegWrite_q    <= RegWrite_in & ~bubble;
            wb_halt_q        <= wb_halt_q | (halt_in & ~bubble);
            wb_pc4_q         <= pc4_in;
            wb_instruction_q <= bubble ? '0 : instruction_in;
        end
    end

    assign mem_stall      = ~RST & (((state_q == IDLE) & is_mem_op & ~sc_fail) | (state_q == ACCESS));
    assign dmemREN        = dmemREN_q;
    assign dmemWEN        = dmemWEN_q;
    assign dmemaddr       = dmemaddr_q;
    assign dmemstore      = dmemstore_q;
    assign wb_wdat        = wb_wdat_q;
    assign wb_wsel        = wb_wsel_q;
    assign wb_RegWrite    = wb_RegWrite_q;
    assign wb_halt        = wb_halt_q;
    assign wb_pc4         = wb_pc4_q;
    assign wb_instruction = wb_instruction_q;
endmodule

// File: tb/tb_memory_stage.sv
`timescale 1ns/1ps
module tb_memory_stage;
    logic        CLK = 1'b0, RST, ihit, flush, dREN_in, dWEN_in, datomic_in;
    logic        MemtoReg_in, RegWrite_in, jal_in, halt_in, dhit, link_inv;
    logic [31:0] aluout_in, rdat2_in, pc4_in, instruction_in, dmemload, link_inv_addr;
    logic [4:0]  wsel_in;
    logic        dmemREN, dmemWEN, mem_stall, wb_RegWrite, wb_halt;
    logic [31:0] dmemaddr, dmemstore, wb_wdat, wb_pc4, wb_instruction;
    logic [4:0]  wb_wsel;

    memory_stage dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .flush(flush),
        .dREN_in(dREN_in), .dWEN_in(dWEN_in), .datomic_in(datomic_in),
        .MemtoReg_in(MemtoReg_in), .RegWrite_in(RegWrite_in), .jal_in(jal_in), .halt_in(halt_in),
        .aluout_in(aluout_in), .rdat2_in(rdat2_in), .wsel_in(wsel_in),
        .pc4_in(pc4_in), .instruction_in(instruction_in),
        .dhit(dhit), .dmemload(dmemload), .link_inv(link_inv), .link_inv_addr(link_inv_addr),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .mem_stall(mem_stall), .wb_wdat(wb_wdat), .wb_wsel(wb_wsel), .wb_RegWrite(wb_RegWrite),
        .wb_halt(wb_halt), .wb_pc4(wb_pc4), .wb_instruction(wb_instruction)
    );

    always #5 CLK = ~CLK;

    localparam int K_ALU = 0, K_LW = 1, K_SW = 2, K_JAL = 3, K_LL = 4, K_SC = 5;

    typedef struct {
        logic ren, wen, atomic, m2r, rw, jal, halt;
        logic [31:0] alu, st, pc4, instr, ld;
        logic [4:0] wsel;
    } op_t;

    typedef struct {
        int cycles, stall, ren, wen, first_req;
        bit unstable, timeout;
        logic [31:0] addr, store, wdat, pc4, instr;
        logic [4:0] wsel;
        logic rw, halt;
    } obs_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: the reservation and the sticky halt, as the ISA sees them.
    bit          m_link_v;
    logic [31:0] m_link_a;
    bit          m_halt;

    function automatic op_t mk_op(input int kind, input logic [31:0] a, input logic [31:0] s);
        op_t o;
        o = '{default: 0};
        o.alu = a; o.st = s;
        o.wsel = 5'($urandom_range(1, 31));
        o.pc4 = $urandom; o.instr = $urandom | 32'h1; o.ld = $urandom;
        case (kind)
            K_ALU: o.rw = 1;
            K_LW:  begin o.ren = 1; o.m2r = 1; o.rw = 1; end
            K_SW:  o.wen = 1;
            K_JAL: begin o.jal = 1; o.rw = 1; end
            K_LL:  begin o.ren = 1; o.atomic = 1; o.m2r = 1; o.rw = 1; end
            default: begin o.wen = 1; o.atomic = 1; o.rw = 1; end
        endcase
        return o;
    endfunction

    task automatic drive_op(input op_t o);
        dREN_in = o.ren; dWEN_in = o.wen; datomic_in = o.atomic; MemtoReg_in = o.m2r;
        RegWrite_in = o.rw; jal_in = o.jal; halt_in = o.halt; aluout_in = o.alu;
        rdat2_in = o.st; wsel_in = o.wsel; pc4_in = o.pc4; instruction_in = o.instr;
    endtask

    task automatic drive_idle();
        op_t z;
        z = '{default: 0};
        drive_op(z);
        ihit = 0; flush = 0; dhit = 0; link_inv = 0; link_inv_addr = 0; dmemload = 0;
    endtask

    task automatic apply_reset();
        drive_idle();
        RST = 1;
        repeat (2) @(negedge CLK);
        RST = 0;
        m_link_v = 0; m_link_a = 0; m_halt = 0;
    endtask

    // Plays the cache (dhit after d request cycles) and the pipeline (ihit from cycle k on).
    task automatic do_op(input op_t o, input int d, input int k, input int inv_cyc,
                         input logic [31:0] inv_a, input int flush_cyc, output obs_t ob);
        int c, nreq;
        bit loaded, req;
        ob = '{default: 0};
        ob.first_req = -1;
        c = 0; nreq = 0; loaded = 0;
        while (!loaded && c < 60) begin
            req = dmemREN | dmemWEN;
            if (req) begin
                if (nreq == 0) begin
                    ob.first_req = c; ob.addr = dmemaddr; ob.store = dmemstore;
                end else if (dmemaddr !== ob.addr || dmemstore !== ob.store) begin
                    ob.unstable = 1;
                end
                nreq++;
                if (dmemREN) ob.ren++;
                if (dmemWEN) ob.wen++;
            end
            drive_op(o);
            dhit = req && (nreq == d);
            dmemload = dhit ? o.ld : $urandom;
            ihit = (c >= k);
            link_inv = (c == inv_cyc);
            link_inv_addr = inv_a;
            flush = (c == flush_cyc);
            #1;
            if (mem_stall) ob.stall++;
            if (ihit && !mem_stall) loaded = 1;
            c++;
            @(negedge CLK);
        end
        ob.cycles = c; ob.timeout = !loaded;
        ob.wdat = wb_wdat; ob.wsel = wb_wsel; ob.rw = wb_RegWrite; ob.halt = wb_halt;
        ob.pc4 = wb_pc4; ob.instr = wb_instruction;
        drive_idle();
    endtask

    task automatic test_reset();
        drive_idle();
        RST = 1;
        #3;
        n_checks++;
        if ({dmemREN, dmemWEN, mem_stall, wb_RegWrite, wb_halt} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 00000", {dmemREN, dmemWEN, mem_stall, wb_RegWrite, wb_halt});
        end
        n_checks++;
        if ({dmemaddr, dmemstore, wb_wdat, wb_pc4, wb_instruction, wb_wsel} !== '0) begin
            n_fail++; $display("FAIL reset_data: got nonzero data outputs addr=%h wdat=%h", dmemaddr, wb_wdat);
        end
        @(negedge CLK); @(negedge CLK);
        RST = 0;
        m_link_v = 0; m_link_a = 0; m_halt = 0;
    endtask

    task automatic test_load();
        op_t o; obs_t ob;
        o = mk_op(K_LW, 32'h0000_0040, 32'h0);
        do_op(o, 2, 0, -1, 0, -1, ob);
        n_checks++; if (ob.ren != 2) begin n_fail++; $display("FAIL lw_ren_cycles: got %0d expected 2", ob.ren); end
        n_checks++; if (ob.first_req != 1) begin n_fail++; $display("FAIL lw_req_latency: got %0d expected 1", ob.first_req); end
        n_checks++; if (ob.addr !== 32'h40 || ob.unstable) begin n_fail++; $display("FAIL lw_addr: got %h unstable=%0d expected 00000040", ob.addr, ob.unstable); end
        n_checks++; if (ob.stall != 3 || ob.cycles != 4) begin n_fail++; $display("FAIL lw_timing: got stall=%0d cycles=%0d expected 3/4", ob.stall, ob.cycles); end
        n_checks++; if (ob.wdat !== o.ld || ob.wsel !== o.wsel || ob.rw !== 1'b1) begin
            n_fail++; $display("FAIL lw_wb: got %h/%0d/%b expected %h/%0d/1", ob.wdat, ob.wsel, ob.rw, o.ld, o.wsel);
        end
    endtask

    task automatic test_store();
        op_t o; obs_t ob;
        o = mk_op(K_SW, 32'h0000_0080, 32'hDEAD_BEEF);
        do_op(o, 1, 0, -1, 0, -1, ob);
        n_checks++; if (ob.wen != 1 || ob.ren != 0) begin n_fail++; $display("FAIL sw_req: got wen=%0d ren=%0d expected 1/0", ob.wen, ob.ren); end
        n_checks++; if (ob.addr !== 32'h80 || ob.store !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL sw_bus: got %h/%h expected 00000080/deadbeef", ob.addr, ob.store);
        end
        n_checks++; if (ob.rw !== 1'b0) begin n_fail++; $display("FAIL sw_regwrite: got %b expected 0", ob.rw); end
        o = mk_op(K_SW, 32'h0000_0083, 32'h1234_5678);
        do_op(o, 1, 0, -1, 0, -1, ob);
        n_checks++; if (ob.addr !== 32'h83) begin n_fail++; $display("FAIL sw_lowbits: got %h expected 00000083", ob.addr); end
    endtask

`ifdef LLSC_EN
    task automatic test_llsc();
        op_t o; obs_t ob;
        o = mk_op(K_LL, 32'h100, 0); do_op(o, 1, 0, -1, 0, -1, ob);
        n_checks++; if (ob.wdat !== o.ld) begin n_fail++; $display("FAIL ll_data: got %h expected %h", ob.wdat, o.ld); end
        o = mk_op(K_SC, 32'h100, 32'h55); do_op(o, 1, 0, -1, 0, -1, ob);
        n_checks++; if (ob.wen != 1 || ob.wdat !== 32'd1) begin n_fail++; $display("FAIL sc_ok: got wen=%0d wdat=%h expected 1/1", ob.wen, ob.wdat); end
        o = mk_op(K_SC, 32'h100, 32'h66); do_op(o, 1, 0, -1, 0, -1, ob);
        n_checks++; if (ob.wen != 0 || ob.wdat !== 32'd0 || ob.cycles != 1) begin
            n_fail++; $display("FAIL sc_second: got wen=%0d wdat=%h cycles=%0d expected 0/0/1", ob.wen, ob.wdat, ob.cycles);
        end
    endtask

    task automatic test_link_inv();
        op_t o; obs_t ob;
        o = mk_op(K_LL, 32'h100, 0); do_op(o, 1, 0, -1, 0, -1, ob);
        o = mk_op(K_ALU, 32'h7, 0);  do_op(o, 1, 0, 0, 32'h100, -1, ob);
        o = mk_op(K_SC, 32'h100, 1); do_op(o, 1, 0, -1, 0, -1, ob);
        n_checks++; if (ob.wen != 0 || ob.wdat !== 32'd0) begin n_fail++; $display("FAIL sc_after_inv: got wen=%0d wdat=%h expected 0/0", ob.wen, ob.wdat); end
        o = mk_op(K_LL, 32'h100, 0); do_op(o, 1, 0, -1, 0, -1, ob);
        o = mk_op(K_SC, 32'h100, 2); do_op(o, 1, 0, 0, 32'h100, -1, ob);
        n_checks++; if (ob.wen != 0 || ob.wdat !== 32'd0) begin n_fail++; $display("FAIL sc_inv_same_cycle: got wen=%0d wdat=%h expected 0/0", ob.wen, ob.wdat); end
        o = mk_op(K_LL, 32'h100, 0); do_op(o, 1, 0, -1, 0, -1, ob);
        o = mk_op(K_ALU, 32'h9, 0);  do_op(o, 1, 0, 0, 32'h104, -1, ob);
        o = mk_op(K_SC, 32'h100, 3); do_op(o, 2, 0, 1, 32'h100, -1, ob);
        n_checks++; if (ob.wen != 2 || ob.wdat !== 32'd1) begin n_fail++; $display("FAIL sc_inv_in_access: got wen=%0d wdat=%h expected 2/1", ob.wen, ob.wdat); end
    endtask
`else
    task automatic test_atomic_off();
        op_t o; obs_t ob;
        o = mk_op(K_SC, 32'h100, 32'h77); do_op(o, 1, 0, -1, 0, -1, ob);
        n_checks++; if (ob.wen != 1 || ob.wdat !== 32'h100) begin n_fail++; $display("FAIL sc_as_sw: got wen=%0d wdat=%h expected 1/00000100", ob.wen, ob.wdat); end
        o = mk_op(K_LL, 32'h104, 0); do_op(o, 1, 0, -1, 0, -1, ob);
        n_checks++; if (ob.ren != 1 || ob.wdat !== o.ld) begin n_fail++; $display("FAIL ll_as_lw: got ren=%0d wdat=%h expected 1/%h", ob.ren, ob.wdat, o.ld); end
    endtask
`endif

    task automatic test_flush();
        op_t o; obs_t ob;
        o = mk_op(K_LW, 32'h40, 0); do_op(o, 2, 0, -1, 0, 1, ob);
        n_checks++; if (ob.ren != 2 || ob.rw !== 1'b0 || ob.instr !== 32'h0) begin
            n_fail++; $display("FAIL flush_access: got ren=%0d rw=%b instr=%h expected 2/0/0", ob.ren, ob.rw, ob.instr);
        end
        o = mk_op(K_SW, 32'h80, 32'h1); do_op(o, 1, 0, -1, 0, 0, ob);
        n_checks++; if (ob.wen != 0 || ob.instr !== 32'h0 || ob.cycles != 1) begin
            n_fail++; $display("FAIL flush_idle: got wen=%0d instr=%h cycles=%0d expected 0/0/1", ob.wen, ob.instr, ob.cycles);
        end
`ifdef LLSC_EN
        o = mk_op(K_LL, 32'h200, 0); do_op(o, 1, 0, -1, 0, 1, ob);
        o = mk_op(K_SC, 32'h200, 5); do_op(o, 1, 0, -1, 0, -1, ob);
        n_checks++; if (ob.wen != 0 || ob.wdat !== 32'd0) begin n_fail++; $display("FAIL flushed_ll_link: got wen=%0d wdat=%h expected 0/0", ob.wen, ob.wdat); end
`endif
    endtask

    task automatic test_ihit_hold();
        op_t o; obs_t ob;
        o = mk_op(K_LW, 32'h44, 0); do_op(o, 1, 6, -1, 0, -1, ob);
        n_checks++; if (ob.cycles != 7 || ob.stall != 2) begin
            n_fail++; $display("FAIL ihit_hold: got cycles=%0d stall=%0d expected 7/2", ob.cycles, ob.stall);
        end
        n_checks++; if (ob.wdat !== o.ld) begin n_fail++; $display("FAIL ihit_hold_data: got %h expected %h", ob.wdat, o.ld); end
    endtask

    task automatic test_halt();
        op_t o; obs_t ob;
        o = mk_op(K_ALU, 32'h1, 0); o.halt = 1; do_op(o, 1, 0, -1, 0, -1, ob);
        n_checks++; if (ob.halt !== 1'b1) begin n_fail++; $display("FAIL halt_set: got %b expected 1", ob.halt); end
        o = mk_op(K_JAL, 32'h2, 0); do_op(o, 1, 0, -1, 0, -1, ob);
        n_checks++; if (ob.halt !== 1'b1 || ob.wdat !== o.pc4) begin
            n_fail++; $display("FAIL halt_sticky_jal: got halt=%b wdat=%h expected 1/%h", ob.halt, ob.wdat, o.pc4);
        end
    endtask

    task automatic test_reset_mid();
        op_t o;
`ifdef LLSC_EN
        obs_t ob;
        o = mk_op(K_LL, 32'h100, 0); do_op(o, 1, 0, -1, 0, -1, ob);
`endif
        o = mk_op(K_LW, 32'h40, 0);
        drive_op(o); ihit = 1;
        @(negedge CLK);
        n_checks++; if (dmemREN !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre: got dmemREN=%b expected 1", dmemREN); end
        #2 RST = 1;
        #1;
        n_checks++; if ({dmemREN, mem_stall, wb_RegWrite, wb_halt} !== 4'b0 || {wb_wdat, wb_wsel, wb_pc4, wb_instruction} !== '0) begin
            n_fail++; $display("FAIL rst_mid: got ren=%b stall=%b wdat=%h instr=%h expected all 0", dmemREN, mem_stall, wb_wdat, wb_instruction);
        end
        @(negedge CLK);
        drive_idle(); RST = 0;
        m_link_v = 0; m_halt = 0;
`ifdef LLSC_EN
        o = mk_op(K_SC, 32'h100, 9); do_op(o, 1, 0, -1, 0, -1, ob);
        n_checks++; if (ob.wen != 0 || ob.wdat !== 32'd0) begin n_fail++; $display("FAIL rst_sc: got wen=%0d wdat=%h expected 0/0", ob.wen, ob.wdat); end
`endif
    endtask

    task automatic test_random();
        op_t o; obs_t ob;
        logic [31:0] addrs [3];
        int kind, d, k, inv_cyc, lc, e_stall, e_ren, e_wen;
        logic [31:0] inv_a, e_wdat;
        bit ll, sc, succ, access;
        addrs[0] = 32'h100; addrs[1] = 32'h104; addrs[2] = 32'h200;
        apply_reset();
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 5);
            o = mk_op(kind, (kind == K_ALU || kind == K_JAL) ? $urandom : addrs[$urandom_range(0, 2)], $urandom);
            o.halt = ($urandom_range(0, 15) == 0);
            d = $urandom_range(1, 3); k = $urandom_range(0, 3);
            inv_cyc = (kind == K_LL) ? -1 : $urandom_range(0, 2) - 1;
            inv_a = addrs[$urandom_range(0, 2)];
            // Reference: ISA-level LL/SC semantics and stage timing from the op's shape.
`ifdef LLSC_EN
            ll = o.ren & o.atomic; sc = o.wen & o.atomic;
`else
            ll = 0; sc = 0;
`endif
            succ = m_link_v && (m_link_a == o.alu) && !(inv_cyc == 0 && inv_a == o.alu);
            access = (o.ren || o.wen) && !(sc && !succ);
            lc = access ? ((d + 1 > k) ? d + 1 : k) : k;
            e_stall = access ? d + 1 : 0;
            e_ren = (access && o.ren) ? d : 0;
            e_wen = (access && o.wen) ? d : 0;
            e_wdat = o.jal ? o.pc4 : sc ? {31'b0, succ} : o.m2r ? o.ld : o.alu;
            if (inv_cyc >= 0 && inv_cyc <= lc && m_link_v && m_link_a == inv_a) m_link_v = 0;
            if (access && o.wen && m_link_a == o.alu) m_link_v = 0;
            if (access && ll) begin m_link_v = 1; m_link_a = o.alu; end
            m_halt = m_halt | o.halt;
            do_op(o, d, k, inv_cyc, inv_a, -1, ob);
            n_checks++; if (ob.timeout || ob.cycles != lc + 1 || ob.stall != e_stall) begin
                n_fail++; $display("FAIL rnd_timing[%0d]: got cycles=%0d stall=%0d expected %0d/%0d", n, ob.cycles, ob.stall, lc + 1, e_stall);
            end
            n_checks++; if (ob.ren != e_ren || ob.wen != e_wen) begin
                n_fail++; $display("FAIL rnd_req[%0d]: got ren=%0d wen=%0d expected %0d/%0d", n, ob.ren, ob.wen, e_ren, e_wen);
            end
            n_checks++; if (access && (ob.addr !== o.alu || ob.store !== o.st || ob.unstable)) begin
                n_fail++; $display("FAIL rnd_bus[%0d]: got %h/%h expected %h/%h", n, ob.addr, ob.store, o.alu, o.st);
            end
            n_checks++; if (ob.wdat !== e_wdat || ob.wsel !== o.wsel || ob.rw !== o.rw) begin
                n_fail++; $display("FAIL rnd_wb[%0d]: got %h/%0d/%b expected %h/%0d/%b", n, ob.wdat, ob.wsel, ob.rw, e_wdat, o.wsel, o.rw);
            end
            n_checks++; if (ob.instr !== o.instr || ob.pc4 !== o.pc4 || ob.halt !== m_halt) begin
                n_fail++; $display("FAIL rnd_trace[%0d]: got %h/%h/%b expected %h/%h/%b", n, ob.instr, ob.pc4, ob.halt, o.instr, o.pc4, m_halt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
`ifdef LLSC_EN
        test_llsc();
        test_link_inv();
`else
        test_atomic_off();
`endif
        test_flush();
        test_ihit_hold();
        test_halt();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
